// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, data width and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

    // Clock cycles per line bit, integer-truncated.
    function automatic int unsigned bitPeriod(input int unsigned clockRate,
                                              input int unsigned baudRate);
        return clockRate / baudRate;
    endfunction

endpackage

// File: rtl/uart8_tx_buffered_if.sv
// Byte-producer handshake into the buffered UART transmitter.
interface uart8_tx_buffered_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] inByte;
    logic                 inValid;
    logic                 inReady;

    modport master (output inByte, output inValid, input inReady);
    modport slave  (input inByte, input inValid, output inReady);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       push,
    input  logic [DATA_BITS-1:0]       din,
    input  logic                       pop,
    output logic [DATA_BITS-1:0]       dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_V = FIFO_DEPTH[AW:0];

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_V);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push / pop.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Byte storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart8_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end, bit timer and frame FSM.
module uart8_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        txEn,
    uart8_tx_buffered_if.slave          bus,
    output logic                        tx,
    output logic                        txBusy,
    output logic                        txDone,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount
);
    localparam int unsigned BIT = bitPeriod(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned CW  = (BIT > 1) ? $clog2(BIT) : 1;
    localparam int unsigned IW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    tx_state_e            state, state_next;
    logic [CW-1:0]        bit_cnt, cnt_next;
    logic [IW-1:0]        bit_idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 tx_next;
    logic                 done_next;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_last;
    logic                 can_start;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (bus.inValid),
        .din   (bus.inByte),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifoCount),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.inReady = !fifo_full;
    assign txBusy      = (state != IDLE);
    assign bit_last    = (bit_cnt == BIT_LAST);
    assign can_start   = txEn && !fifo_empty;

    // Next-state, bit timing, shift and registered-line decode.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt + 1'b1;
        idx_next   = bit_idx;
        shift_next = shift;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (can_start) begin
                    state_next = START;
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                end
            end
            START: begin
                if (bit_last) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) state_next = STOP;
                    else                     idx_next   = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (bit_last) begin
                    cnt_next = '0;
                    if (can_start) begin
                        state_next = START;
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is decoded from the state being entered so tx can be a flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        done_next = (state == STOP) && bit_last;
    end

    // State, timers, shift register and line outputs.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            txDone  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
            bit_idx <= idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
            txDone  <= done_next;
        end
    end

endmodule

// File: tb/tb_uart8_tx_buffered.sv
// Self-checking bench for uart8_tx_buffered. A frame-level reference model
// (byte queue + position within a 10-bit frame) is compared every cycle,
// alongside table-driven single-frame vectors and directed corner sequences.
// The clock rate is chosen so the bit period is a small, non-power-of-two 13.
module tb_uart8_tx_buffered;
    localparam int unsigned CLOCK_RATE = 124805;
    localparam int unsigned BAUD_RATE  = 9600;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int BIT   = CLOCK_RATE / BAUD_RATE;
    localparam int FRAME = 10 * BIT;
    localparam int CNTW  = $clog2(FIFO_DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rstN;
    logic            txEn;
    logic            tx;
    logic            txBusy;
    logic            txDone;
    logic [CNTW-1:0] fifoCount;

    uart8_tx_buffered_if bus();

    uart8_tx_buffered #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .txEn     (txEn),
        .bus      (bus.slave),
        .tx       (tx),
        .txBusy   (txBusy),
        .txDone   (txDone),
        .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: queued bytes, byte on the line, cycle position in frame.
    byte unsigned mq[$];
    int           m_pos = -1;
    logic [7:0]   m_byte = '0;
    logic         m_done = 1'b0;
    bit           model_on = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic m_tx();
        int lvl;
        if (m_pos < 0) return 1'b1;
        lvl = m_pos / BIT;
        if (lvl == 0) return 1'b0;
        if (lvl >= 9) return 1'b1;
        return m_byte[lvl-1];
    endfunction

    task automatic model_step();
        bit rdy;
        bit at_end;
        bit start;
        if (!rstN) begin
            mq.delete();
            m_pos    = -1;
            m_done   = 1'b0;
            model_on = 1'b1;
        end else begin
            rdy    = (mq.size() != FIFO_DEPTH);
            at_end = (m_pos == FRAME - 1);
            start  = (m_pos < 0 || at_end) && (mq.size() > 0) && (txEn === 1'b1);
            m_done = at_end;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME) m_pos = -1;
            end
            if (start) begin
                m_byte = mq.pop_front();
                m_pos  = 0;
            end
            if (bus.inValid === 1'b1 && rdy) mq.push_back(bus.inByte);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (model_on)
            check("model", {tx, txBusy, txDone, bus.inReady, fifoCount},
                  {m_tx(), (m_pos >= 0), m_done, (mq.size() != FIFO_DEPTH), CNTW'(mq.size())});
    endtask

    initial begin
        logic [9:0] got;
        logic [7:0] val;
        logic [7:0] fb [4];
        logic       sbit, stopb, rx_err;
        int done_at, ndone, d0, d1, busy_low, gap, bad, waited;

        vecs[0] = '{8'hB5, 10'b1101101010};
        vecs[1] = '{8'h55, 10'b1010101010};
        vecs[2] = '{8'hAA, 10'b1101010100};
        vecs[3] = '{8'hFF, 10'b1111111110};
        vecs[4] = '{8'h00, 10'b1000000000};
        vecs[5] = '{8'h3C, 10'b1001111000};

        rstN = 1'b0; txEn = 1'b0; bus.inValid = 1'b0; bus.inByte = '0;
        tick(); tick();
        check("rst_tx", tx, 1);
        check("rst_busy", txBusy, 0);
        check("rst_done", txDone, 0);
        check("rst_count", fifoCount, 0);
        check("rst_ready", bus.inReady, 1);
        rstN = 1'b1;
        tick();

        // Single frames from the vector table.
        txEn = 1'b1;
        foreach (vecs[i]) begin
            bus.inByte = vecs[i].data; bus.inValid = 1'b1;
            tick();
            bus.inValid = 1'b0;
            check("push_count", fifoCount, 1);
            tick();
            check("first_low", tx, 0);
            got = '0; done_at = -1; ndone = 0;
            for (int j = 0; j < FRAME + 3; j++) begin
                if (j < FRAME && (j % BIT) == BIT / 2) got[j / BIT] = tx;
                if (txDone === 1'b1) begin
                    ndone++;
                    if (done_at < 0) done_at = j;
                end
                tick();
            end
            check("line", got, vecs[i].line);
            check("done_at", done_at, FRAME);
            check("done_pulses", ndone, 1);
            check("busy_after", txBusy, 0);
        end

        // Back-to-back frames.
        txEn = 1'b0;
        bus.inByte = 8'h55; bus.inValid = 1'b1;
        tick();
        check("b2b_cnt1", fifoCount, 1);
        bus.inByte = 8'hAA;
        tick();
        bus.inValid = 1'b0;
        check("b2b_cnt2", fifoCount, 2);
        txEn = 1'b1;
        tick();
        check("b2b_cnt3", fifoCount, 1);
        check("b2b_start", tx, 0);
        d0 = -1; d1 = -1;
        for (int j = 0; j < 2 * FRAME + 3; j++) begin
            if (j == FRAME - 1) check("b2b_stop", tx, 1);
            if (j == FRAME) begin
                check("b2b_restart", tx, 0);
                check("b2b_cnt4", fifoCount, 0);
            end
            if (txDone === 1'b1) begin
                if (d0 < 0) d0 = j;
                else if (d1 < 0) d1 = j;
            end
            tick();
        end
        check("b2b_done1", d0, FRAME);
        check("b2b_spacing", d1 - d0, FRAME);

        // Full FIFO: fifth byte is dropped, four frames go out contiguously.
        txEn = 1'b0;
        bus.inValid = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            bus.inByte = 8'(b);
            tick();
        end
        bus.inValid = 1'b0;
        check("full_count", fifoCount, 4);
        check("full_ready", bus.inReady, 0);
        txEn = 1'b1;
        tick();
        busy_low = 0; gap = 0;
        for (int f = 0; f < 4; f++) fb[f] = '0;
        for (int j = 0; j < 4 * FRAME; j++) begin
            int f, r;
            f = j / FRAME;
            r = j % FRAME;
            if ((r % BIT) == BIT / 2 && r / BIT >= 1 && r / BIT <= 8) fb[f][r / BIT - 1] = tx;
            if (r == BIT / 2 && tx !== 1'b0) gap++;
            if (txBusy !== 1'b1) busy_low++;
            tick();
        end
        for (int f = 0; f < 4; f++) check("full_byte", fb[f], f + 1);
        check("full_start_bits", gap, 0);
        check("full_busy_gap", busy_low, 0);
        check("full_drained", fifoCount, 0);
        tick();

        // Enable dropped during data bit 3 of the first of two bytes.
        bus.inByte = 8'hC3; bus.inValid = 1'b1;
        tick();
        bus.inByte = 8'h3C;
        tick();
        bus.inValid = 1'b0;
        check("drop_start", tx, 0);
        val = '0; ndone = 0; bad = 0;
        for (int j = 0; j < FRAME + 3 * BIT; j++) begin
            if (j == 4 * BIT + 2) txEn = 1'b0;
            if (j < FRAME && (j % BIT) == BIT / 2 && j / BIT >= 1 && j / BIT <= 8) val[j / BIT - 1] = tx;
            if (j >= FRAME && tx !== 1'b1) bad++;
            if (txDone === 1'b1) ndone++;
            tick();
        end
        check("drop_byte", val, 8'hC3);
        check("drop_done", ndone, 1);
        check("drop_line_high", bad, 0);
        check("drop_busy", txBusy, 0);
        check("drop_count", fifoCount, 1);
        txEn = 1'b1;
        tick();
        check("drop_restart_tx", tx, 0);
        check("drop_restart_busy", txBusy, 1);
        check("drop_restart_count", fifoCount, 0);
        for (int j = 0; j < FRAME + 2; j++) tick();

        // Reset during data bit 5 with two bytes still queued.
        txEn = 1'b0;
        bus.inValid = 1'b1;
        bus.inByte = 8'h11; tick();
        bus.inByte = 8'h22; tick();
        bus.inByte = 8'h33; tick();
        bus.inValid = 1'b0;
        txEn = 1'b1;
        tick();
        check("rstmid_queued", fifoCount, 2);
        for (int j = 0; j < 6 * BIT + 3; j++) tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        check("rstmid_tx", tx, 1);
        check("rstmid_busy", txBusy, 0);
        check("rstmid_count", fifoCount, 0);
        check("rstmid_ready", bus.inReady, 1);
        ndone = 0; bad = 0;
        for (int j = 0; j < 12 * BIT; j++) begin
            if (txDone === 1'b1) ndone++;
            if (tx !== 1'b1) bad++;
            tick();
        end
        check("rstmid_no_done", ndone, 0);
        check("rstmid_line_idle", bad, 0);

        // Loopback through a mid-bit sampling receiver.
        bus.inByte = 8'b10110101; bus.inValid = 1'b1;
        tick();
        bus.inValid = 1'b0;
        waited = 0;
        while (tx !== 1'b0 && waited < 4 * BIT) begin
            tick();
            waited++;
        end
        check("lb_start_seen", tx, 0);
        val = '0; sbit = 1'b1; stopb = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
            if (j == BIT / 2) sbit = tx;
            if ((j % BIT) == BIT / 2 && j / BIT >= 1 && j / BIT <= 8) val[j / BIT - 1] = tx;
            if (j == 9 * BIT + BIT / 2) stopb = tx;
            tick();
        end
        rx_err = (sbit !== 1'b0) || (stopb !== 1'b1);
        check("lb_data", val, 8'b10110101);
        check("lb_rxErr", rx_err, 0);
        for (int j = 0; j < 3; j++) tick();

        // Random traffic with enable gaps and rare resets.
        for (int c = 0; c < 3000; c++) begin
            txEn        = ($urandom_range(7) != 0);
            bus.inValid = 1'($urandom_range(1));
            bus.inByte  = 8'($urandom);
            rstN        = ($urandom_range(999) != 0);
            tick();
        end
        rstN = 1'b1; bus.inValid = 1'b0; txEn = 1'b1;
        waited = 0;
        while ((txBusy !== 1'b0 || fifoCount !== '0) && waited < 8 * FRAME) begin
            tick();
            waited++;
        end
        check("drain_idle", {txBusy, fifoCount}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
